// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB, decoded fields registered once per instruction, HALT on faults.
// Latency 4 cycles (ALU/branch/jump), 5 + wait cycles (load/store); a bus strobe is held until its own ack or the wait-state timeout.
module multicycle_ctrl #(
    parameter int                       IO_MATCH_BITS = 16,
    parameter logic [IO_MATCH_BITS-1:0] IO_BASE       = 16'hFFFF,
    parameter bit                       ENABLE_M      = 1'b0,
    parameter int                       TIMEOUT_CYC   = 255,
    parameter int                       ALU_OP_W      = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         inst,
    input  logic [31:0]         addr,
    input  logic                mem_ack,
    input  logic                io_ack,
    output logic [2:0]          state,
    output logic                ir_write,
    output logic                pc_write,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [2:0]          alu_src,
    output logic                branch,
    output logic                mem_read,
    output logic                mem_write,
    output logic                io_read,
    output logic                io_write,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                halted,
    output logic [1:0]          fault
);

    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                           S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT = 3'd5;
    localparam logic [1:0] CL_ALU = 2'd0, CL_LOAD = 2'd1, CL_STORE = 2'd2, CL_BR = 2'd3;
    localparam logic [2:0] SRC_RS2 = 3'd0, SRC_IMM = 3'd1, SRC_LINK = 3'd2,
                           SRC_LUI = 3'd3, SRC_AUIPC = 3'd4, SRC_SHAMT = 3'd5;
    localparam logic [1:0] F_NONE = 2'd0, F_ILL = 2'd1, F_TMO = 2'd2, F_SYS = 2'd3;
    localparam int         WCW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WCW-1:0] TMAX = WCW'(TIMEOUT_CYC);

    logic [2:0]     state_q, state_d;
    logic [4:0]     alu_op_q, alu_op_d;
    logic [2:0]     alu_src_q, alu_src_d;
    logic           branch_q, branch_d;
    logic [1:0]     cls_q, cls_d;
    logic [1:0]     fault_q, fault_d;
    logic           sel_io_q, sel_io_d;
    logic [WCW-1:0] wait_q, wait_d;

    logic [4:0] dec_op;
    logic [2:0] dec_src;
    logic       dec_br;
    logic [1:0] dec_cls;
    logic [1:0] dec_flt;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ack_sel;
    logic       unused_ok;

    assign f3        = inst[14:12];
    assign f7        = inst[31:25];
    assign ack_sel   = sel_io_q ? io_ack : mem_ack;
    // Register/immediate fields and low address bits belong to the datapath.
    assign unused_ok = ^{inst, addr};

    function automatic logic [4:0] alu_f3(input logic [2:0] fn, input logic alt);
        case (fn)
            3'b000:  alu_f3 = alt ? 5'd1 : 5'd0;
            3'b001:  alu_f3 = 5'd2;
            3'b010:  alu_f3 = 5'd10;
            3'b011:  alu_f3 = 5'd12;
            3'b100:  alu_f3 = 5'd5;
            3'b101:  alu_f3 = alt ? 5'd4 : 5'd3;
            3'b110:  alu_f3 = 5'd6;
            default: alu_f3 = 5'd7;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            alu_op_q  <= '0;
            alu_src_q <= '0;
            branch_q  <= 1'b0;
            cls_q     <= CL_ALU;
            fault_q   <= F_NONE;
            sel_io_q  <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            alu_op_q  <= alu_op_d;
            alu_src_q <= alu_src_d;
            branch_q  <= branch_d;
            cls_q     <= cls_d;
            fault_q   <= fault_d;
            sel_io_q  <= sel_io_d;
            wait_q    <= wait_d;
        end
    end

    always_comb begin
        dec_op  = 5'd0;
        dec_src = SRC_RS2;
        dec_br  = 1'b0;
        dec_cls = CL_ALU;
        dec_flt = F_NONE;
        case (inst[6:0])
            7'b0110011: begin
                if (f7 == 7'h01) begin
                    if (ENABLE_M) dec_op = {2'b10, f3};
                    else          dec_flt = F_ILL;
                end else if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    dec_op = alu_f3(f3, f7[5]);
                end else begin
                    dec_flt = F_ILL;
                end
            end
            7'b0010011: begin
                // Immediate shifts carry shamt in the imm field; only srai uses the alt bit.
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec_src = SRC_SHAMT;
                    dec_op  = alu_f3(f3, inst[30]);
                end else begin
                    dec_src = SRC_IMM;
                    dec_op  = alu_f3(f3, 1'b0);
                end
            end
            7'b0000011: begin dec_src = SRC_IMM; dec_cls = CL_LOAD;  end
            7'b0100011: begin dec_src = SRC_IMM; dec_cls = CL_STORE; end
            7'b1100011: begin
                dec_cls = CL_BR;
                dec_br  = 1'b1;
                case (f3)
                    3'b000:  dec_op = 5'd8;
                    3'b001:  dec_op = 5'd9;
                    3'b100:  dec_op = 5'd10;
                    3'b101:  dec_op = 5'd11;
                    3'b110:  dec_op = 5'd12;
                    3'b111:  dec_op = 5'd13;
                    default: dec_flt = F_ILL;
                endcase
            end
            7'b1101111, 7'b1100111: begin dec_src = SRC_LINK; dec_br = 1'b1; end
            7'b0110111: dec_src = SRC_LUI;
            7'b0010111: dec_src = SRC_AUIPC;
            7'b1110011: dec_flt = F_SYS;
            default:    dec_flt = F_ILL;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        fault_d  = fault_q;
        sel_io_d = sel_io_q;
        wait_d   = wait_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (dec_flt != F_NONE) begin
                    state_d = S_HALT;
                    fault_d = dec_flt;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                wait_d = '0;
                if (cls_q == CL_LOAD || cls_q == CL_STORE) begin
                    state_d  = S_MEM;
                    sel_io_d = (addr[31 -: IO_MATCH_BITS] == IO_BASE);
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // An ack arriving on the timeout cycle still completes the access.
                if (ack_sel) begin
                    state_d = S_WB;
                end else if (TIMEOUT_CYC != 0 && wait_q == TMAX) begin
                    state_d = S_HALT;
                    fault_d = F_TMO;
                end else if (wait_q != '1) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        alu_op_d  = alu_op_q;
        alu_src_d = alu_src_q;
        branch_d  = branch_q;
        cls_d     = cls_q;
        if (state_q == S_DECODE) begin
            alu_op_d  = dec_op;
            alu_src_d = dec_src;
            branch_d  = dec_br;
            cls_d     = dec_cls;
        end
    end

    always_comb begin
        state      = state_q;
        alu_op     = ALU_OP_W'(alu_op_q);
        alu_src    = alu_src_q;
        branch     = branch_q;
        fault      = fault_q;
        halted     = (state_q == S_HALT);
        // Reset parks the FSM in FETCH; keep the IR load quiet until reset is released.
        ir_write   = (state_q == S_FETCH) && rst_n;
        pc_write   = (state_q == S_WB);
        reg_write  = (state_q == S_WB) && (cls_q == CL_ALU || cls_q == CL_LOAD);
        mem_to_reg = (state_q == S_WB) && (cls_q == CL_LOAD);
        mem_read   = (state_q == S_MEM) && (cls_q == CL_LOAD)  && !sel_io_q;
        io_read    = (state_q == S_MEM) && (cls_q == CL_LOAD)  &&  sel_io_q;
        mem_write  = (state_q == S_MEM) && (cls_q == CL_STORE) && !sel_io_q;
        io_write   = (state_q == S_MEM) && (cls_q == CL_STORE) &&  sel_io_q;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: vector table driven through a scoreboard queue, plus hand sequences for reset and M-extension cases.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, mem_ack, io_ack;
    logic [31:0] inst, addr;
    logic [2:0]  state, alu_src;
    logic [4:0]  alu_op;
    logic [1:0]  fault;
    logic        ir_write, pc_write, branch, mem_read, mem_write, io_read, io_write;
    logic        mem_to_reg, reg_write, halted;
    logic [2:0]  b_state, b_alu_src;
    logic [4:0]  b_alu_op;
    logic [1:0]  b_fault;
    logic        b_ir_write, b_pc_write, b_branch, b_mem_read, b_mem_write, b_io_read, b_io_write;
    logic        b_mem_to_reg, b_reg_write, b_halted;

    multicycle_ctrl #(.ENABLE_M(1'b1), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .addr(addr), .mem_ack(mem_ack), .io_ack(io_ack),
        .state(state), .ir_write(ir_write), .pc_write(pc_write), .alu_op(alu_op), .alu_src(alu_src),
        .branch(branch), .mem_read(mem_read), .mem_write(mem_write), .io_read(io_read),
        .io_write(io_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .halted(halted),
        .fault(fault)
    );

    multicycle_ctrl #(.ENABLE_M(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .inst(inst), .addr(addr), .mem_ack(mem_ack), .io_ack(io_ack),
        .state(b_state), .ir_write(b_ir_write), .pc_write(b_pc_write), .alu_op(b_alu_op),
        .alu_src(b_alu_src), .branch(b_branch), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .io_read(b_io_read), .io_write(b_io_write), .mem_to_reg(b_mem_to_reg),
        .reg_write(b_reg_write), .halted(b_halted), .fault(b_fault)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          id;
        logic [31:0] inst;
        logic [31:0] addr;
        int          ack_cyc;   // MEM cycle (1-based) carrying the ack; 0 = never
        logic        to_io;
        logic        halt;
        logic [1:0]  fault;
        logic [4:0]  op;
        logic [2:0]  src;
        logic        br;
        logic        rw;
        logic        m2r;
        logic [3:0]  stb;       // {mem_read, mem_write, io_read, io_write}
        int          nstb;
        int          lat;
    } vec_t;

    vec_t vecs[20];
    vec_t sb[$];
    vec_t m_e;
    logic mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] i, input logic [31:0] a, input int ack,
                                input logic io, input logic h, input logic [1:0] f,
                                input logic [4:0] op, input logic [2:0] src, input logic br,
                                input logic rw, input logic m2r, input logic [3:0] stb,
                                input int n, input int lat);
        vec_t v;
        v.id = 0; v.inst = i; v.addr = a; v.ack_cyc = ack; v.to_io = io; v.halt = h;
        v.fault = f; v.op = op; v.src = src; v.br = br; v.rw = rw; v.m2r = m2r;
        v.stb = stb; v.nstb = n; v.lat = lat;
        return v;
    endfunction

    // Scoreboard consumer: per-instruction activity counted from FETCH, compared at WB or first HALT cycle.
    int   m_cyc, n_mr, n_mw, n_ir, n_iw, en_out, multi;
    logic halt_done;
    logic [31:0] exp_cnt;
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (state == 3'd0) begin
                m_cyc = 1; n_mr = 0; n_mw = 0; n_ir = 0; n_iw = 0;
                en_out = 0; multi = 0; halt_done = 1'b0;
            end else begin
                m_cyc++;
            end
            n_mr += 32'(mem_read); n_mw += 32'(mem_write);
            n_ir += 32'(io_read);  n_iw += 32'(io_write);
            if ((reg_write || pc_write) && state != 3'd4) en_out++;
            if (32'(mem_read) + 32'(mem_write) + 32'(io_read) + 32'(io_write) > 1) multi++;
            if (state == 3'd4 || (state == 3'd5 && !halt_done)) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    m_e = sb.pop_front();
                    exp_cnt = {8'(m_e.stb[3] ? m_e.nstb : 0), 8'(m_e.stb[2] ? m_e.nstb : 0),
                               8'(m_e.stb[1] ? m_e.nstb : 0), 8'(m_e.stb[0] ? m_e.nstb : 0)};
                    chk($sformatf("v%0d end_state", m_e.id), 32'(state), m_e.halt ? 32'd5 : 32'd4);
                    chk($sformatf("v%0d latency", m_e.id), 32'(m_cyc), 32'(m_e.lat));
                    chk($sformatf("v%0d strobe_cycles", m_e.id),
                        {n_mr[7:0], n_mw[7:0], n_ir[7:0], n_iw[7:0]}, exp_cnt);
                    chk($sformatf("v%0d enable_outside_wb", m_e.id), 32'(en_out), 32'd0);
                    chk($sformatf("v%0d multi_strobe", m_e.id), 32'(multi), 32'd0);
                    if (m_e.halt) begin
                        chk($sformatf("v%0d fault", m_e.id), 32'(fault), 32'(m_e.fault));
                        chk($sformatf("v%0d halted", m_e.id), 32'(halted), 32'd1);
                        chk($sformatf("v%0d halt_quiet", m_e.id),
                            32'({mem_read, mem_write, io_read, io_write, reg_write, pc_write, ir_write}), 32'd0);
                    end else begin
                        chk($sformatf("v%0d alu_op", m_e.id), 32'(alu_op), 32'(m_e.op));
                        chk($sformatf("v%0d alu_src", m_e.id), 32'(alu_src), 32'(m_e.src));
                        chk($sformatf("v%0d branch", m_e.id), 32'(branch), 32'(m_e.br));
                        chk($sformatf("v%0d reg_write", m_e.id), 32'(reg_write), 32'(m_e.rw));
                        chk($sformatf("v%0d mem_to_reg", m_e.id), 32'(mem_to_reg), 32'(m_e.m2r));
                        chk($sformatf("v%0d pc_write", m_e.id), 32'(pc_write), 32'd1);
                    end
                end
                if (state == 3'd5) halt_done = 1'b1;
            end
        end
    end

    task automatic reset_pulse();
        @(posedge clk);
        #2 rst_n = 1'b0; mem_ack = 1'b0; io_ack = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Producer: drives one instruction, pushes its expectation, answers bus requests with the wrong ack as noise.
    task automatic run_vec(input vec_t v);
        int   mcnt, guard;
        logic done;
        mcnt = 0; guard = 0; done = 1'b0;
        while (state != 3'd0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk($sformatf("v%0d fetch_wait", v.id), 32'(state), 32'd0);
        inst = v.inst;
        addr = v.addr;
        sb.push_back(v);
        guard = 0;
        while (!done && guard < 40) begin
            @(negedge clk);
            guard++;
            case (state)
                3'd2: inst = $urandom;
                3'd3: begin
                    mcnt++;
                    addr = $urandom;
                    if (v.to_io) begin io_ack = (mcnt == v.ack_cyc); mem_ack = 1'b1; end
                    else         begin mem_ack = (mcnt == v.ack_cyc); io_ack = 1'b1; end
                end
                3'd4, 3'd5: begin mem_ack = 1'b0; io_ack = 1'b0; done = 1'b1; end
                default: ;
            endcase
        end
        chk($sformatf("v%0d completed", v.id), 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] trace[5];
        trace = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};

        //                inst          addr          ack io h  flt  op     src   br rw m2r stb      n  lat
        vecs[0]  = mk(32'h003100B3, 32'h0,        0, 0, 0, 2'd0, 5'd0,  3'd0, 0, 1, 0, 4'b0000, 0, 4);
        vecs[1]  = mk(32'h403100B3, 32'h0,        0, 0, 0, 2'd0, 5'd1,  3'd0, 0, 1, 0, 4'b0000, 0, 4);
        vecs[2]  = mk(32'h0000A283, 32'h00001000, 3, 0, 0, 2'd0, 5'd0,  3'd1, 0, 1, 1, 4'b1000, 3, 7);
        vecs[3]  = mk(32'h0050A023, 32'hFFFFFC60, 1, 1, 0, 2'd0, 5'd0,  3'd1, 0, 0, 0, 4'b0001, 1, 5);
        vecs[4]  = mk(32'h40315093, 32'h0,        0, 0, 0, 2'd0, 5'd4,  3'd5, 0, 1, 0, 4'b0000, 0, 4);
        vecs[5]  = mk(32'h00208463, 32'h0,        0, 0, 0, 2'd0, 5'd8,  3'd0, 1, 0, 0, 4'b0000, 0, 4);
        vecs[6]  = mk(32'h0020E463, 32'h0,        0, 0, 0, 2'd0, 5'd12, 3'd0, 1, 0, 0, 4'b0000, 0, 4);
        vecs[7]  = mk(32'h010000EF, 32'h0,        0, 0, 0, 2'd0, 5'd0,  3'd2, 1, 1, 0, 4'b0000, 0, 4);
        vecs[8]  = mk(32'h123450B7, 32'h0,        0, 0, 0, 2'd0, 5'd0,  3'd3, 0, 1, 0, 4'b0000, 0, 4);
        vecs[9]  = mk(32'h00001097, 32'h0,        0, 0, 0, 2'd0, 5'd0,  3'd4, 0, 1, 0, 4'b0000, 0, 4);
        vecs[10] = mk(32'h022081B3, 32'h0,        0, 0, 0, 2'd0, 5'd16, 3'd0, 0, 1, 0, 4'b0000, 0, 4);
        vecs[11] = mk(32'h023170B3, 32'h0,        0, 0, 0, 2'd0, 5'd23, 3'd0, 0, 1, 0, 4'b0000, 0, 4);
        vecs[12] = mk(32'h0050A023, 32'h00002000, 2, 0, 0, 2'd0, 5'd0,  3'd1, 0, 0, 0, 4'b0100, 2, 6);
        vecs[13] = mk(32'h0000A283, 32'hFFFF0004, 5, 1, 0, 2'd0, 5'd0,  3'd1, 0, 1, 1, 4'b0010, 5, 9);
        vecs[14] = mk(32'h0000A283, 32'hFFFF0004, 0, 1, 1, 2'd2, 5'd0,  3'd0, 0, 0, 0, 4'b0010, 5, 9);
        vecs[15] = mk(32'h00000073, 32'h0,        0, 0, 1, 2'd3, 5'd0,  3'd0, 0, 0, 0, 4'b0000, 0, 3);
        vecs[16] = mk(32'hFFFFFFFF, 32'h0,        0, 0, 1, 2'd1, 5'd0,  3'd0, 0, 0, 0, 4'b0000, 0, 3);
        vecs[17] = mk(32'hFE3100B3, 32'h0,        0, 0, 1, 2'd1, 5'd0,  3'd0, 0, 0, 0, 4'b0000, 0, 3);
        vecs[18] = mk(32'hFFF10093, 32'h0,        0, 0, 0, 2'd0, 5'd0,  3'd1, 0, 1, 0, 4'b0000, 0, 4);
        vecs[19] = mk(32'h0000A283, 32'hFFFE0000, 1, 0, 0, 2'd0, 5'd0,  3'd1, 0, 1, 1, 4'b1000, 1, 5);
        for (int i = 0; i < 20; i++) vecs[i].id = i;

        rst_n = 1'b0; inst = '0; addr = '0; mem_ack = 1'b0; io_ack = 1'b0;
        #12;
        chk("reset state", 32'(state), 32'd0);
        chk("reset outputs", 32'({ir_write, pc_write, reg_write, mem_to_reg, mem_read, mem_write,
                                  io_read, io_write, halted, branch, fault, alu_op, alu_src}), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset ir_write", 32'(ir_write), 32'd1);

        // add: state trace, reg_write only in WB, inst changes after DECODE ignored
        inst = 32'h003100B3;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 2) inst = 32'h00000073;
            chk($sformatf("add state[%0d]", k), 32'(state), 32'(trace[k]));
            chk($sformatf("add reg_write[%0d]", k), 32'(reg_write), 32'(trace[k] == 3'd4));
        end

        // async reset in the middle of a pending load
        reset_pulse();
        inst = 32'h0000A283;
        addr = 32'h00001000;
        for (int g = 0; g < 10 && state != 3'd3; g++) @(negedge clk);
        @(negedge clk);
        chk("mid-MEM mem_read", 32'({mem_read, io_read}), 32'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset state", 32'(state), 32'd0);
        chk("async reset outputs", 32'({ir_write, pc_write, reg_write, mem_to_reg, mem_read, mem_write,
                                        io_read, io_write, halted, fault, alu_op, alu_src}), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("after release state/ir_write", 32'({state, ir_write}), 32'b0001);

        mon_en = 1'b1;
        reset_pulse();
        for (int i = 0; i < 20; i++) begin
            run_vec(vecs[i]);
            if (vecs[i].halt) begin
                repeat (3) @(negedge clk);
                chk($sformatf("v%0d halt_sticky", i), 32'({state, halted}), 32'b1011);
                reset_pulse();
            end
        end
        @(negedge clk);
        mon_en = 1'b0;
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        // mul on both builds: decoded with the M extension, illegal without it
        reset_pulse();
        inst = 32'h022081B3;
        repeat (2) @(negedge clk);
        chk("M=1 mul state", 32'(state), 32'd2);
        chk("M=1 mul alu_op", 32'(alu_op), 32'd16);
        chk("M=0 mul state", 32'(b_state), 32'd5);
        chk("M=0 mul fault", 32'(b_fault), 32'd1);
        chk("M=0 mul halted", 32'(b_halted), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
